// File: rtl/cgra_cfg_arbiter_if.sv
// rtl/cgra_cfg_arbiter_if.sv - master-side command/response and CGRA cfg port bundle
interface cgra_cfg_arbiter_if #(
    parameter int NUM_REQ             = 4,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [NUM_REQ-1:0]                          req_write;
    logic [NUM_REQ-1:0]                          req_last;
    logic [NUM_REQ-1:0][CGRA_CFG_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][CGRA_CFG_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                          rsp_valid;
    logic [CGRA_CFG_DATA_WIDTH-1:0]              rsp_rdata;
    logic                                        cfg_wr_en;
    logic [CGRA_CFG_ADDR_WIDTH-1:0]              cfg_wr_addr;
    logic [CGRA_CFG_DATA_WIDTH-1:0]              cfg_wr_data;
    logic                                        cfg_rd_en;
    logic [CGRA_CFG_ADDR_WIDTH-1:0]              cfg_rd_addr;
    logic [CGRA_CFG_DATA_WIDTH-1:0]              cfg_rd_data;
    logic                                        busy;

    // Arbiter view.
    modport slave (
        input  req_valid, req_write, req_last, req_addr, req_wdata, cfg_rd_data,
        output req_ready, rsp_valid, rsp_rdata,
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr, busy
    );

    // Masters plus CGRA view.
    modport master (
        output req_valid, req_write, req_last, req_addr, req_wdata, cfg_rd_data,
        input  req_ready, rsp_valid, rsp_rdata,
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr, busy
    );
endinterface

// File: rtl/cgra_cfg_arbiter.sv
// rtl/cgra_cfg_arbiter.sv - round-robin cfg port arbiter with burst lock and read return
module cgra_cfg_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 reset_n,
    cgra_cfg_arbiter_if.slave   bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDW-1:0] id_t;
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t state_q, state_d;
    id_t    owner_q, owner_d;
    id_t    rr_ptr_q, rr_ptr_d;
    id_t    rd_id_q, rd_id_d;
    id_t    grant_idx, scan_idx, sel;
    logic   grant_found, hs, hs_wr, hs_rd;
    logic [NUM_REQ-1:0] ready_c;

    logic                           cfg_wr_en_q, cfg_wr_en_d, cfg_rd_en_q, cfg_rd_en_d;
    logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_wr_addr_q, cfg_wr_addr_d, cfg_rd_addr_q, cfg_rd_addr_d;
    logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data_q, cfg_wr_data_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [CGRA_CFG_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // First valid master at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = id_t'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        ready_c  = '0;
        sel      = (state_q == ST_LOCKED) ? owner_q : grant_idx;
        case (state_q)
            ST_IDLE:   ready_c[grant_idx] = grant_found;
            ST_LOCKED: ready_c[owner_q]   = bus.req_valid[owner_q];
            default:   ready_c = '0;
        endcase
        if (!reset_n) ready_c = '0;
        hs = |(bus.req_valid & ready_c);
        if (hs) begin
            if (bus.req_last[sel]) begin
                // A whole burst counts as one turn: the pointer moves only here.
                state_d  = ST_IDLE;
                rr_ptr_d = (sel == id_t'(NUM_REQ - 1)) ? '0 : sel + id_t'(1);
            end else begin
                state_d = ST_LOCKED;
                owner_d = sel;
            end
        end
    end

    always_comb begin
        hs_wr         = hs & bus.req_write[sel];
        hs_rd         = hs & ~bus.req_write[sel];
        cfg_wr_en_d   = hs_wr;
        cfg_wr_addr_d = hs_wr ? bus.req_addr[sel]  : '0;
        cfg_wr_data_d = hs_wr ? bus.req_wdata[sel] : '0;
        cfg_rd_en_d   = hs_rd;
        cfg_rd_addr_d = hs_rd ? bus.req_addr[sel]  : '0;
        rd_id_d       = sel;
        rsp_valid_d   = '0;
        if (cfg_rd_en_q) rsp_valid_d[rd_id_q] = 1'b1;
        rsp_rdata_d   = cfg_rd_en_q ? bus.cfg_rd_data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            rd_id_q       <= '0;
            cfg_wr_en_q   <= 1'b0;
            cfg_wr_addr_q <= '0;
            cfg_wr_data_q <= '0;
            cfg_rd_en_q   <= 1'b0;
            cfg_rd_addr_q <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_id_q       <= rd_id_d;
            cfg_wr_en_q   <= cfg_wr_en_d;
            cfg_wr_addr_q <= cfg_wr_addr_d;
            cfg_wr_data_q <= cfg_wr_data_d;
            cfg_rd_en_q   <= cfg_rd_en_d;
            cfg_rd_addr_q <= cfg_rd_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.cfg_wr_en   = cfg_wr_en_q;
    assign bus.cfg_wr_addr = cfg_wr_addr_q;
    assign bus.cfg_wr_data = cfg_wr_data_q;
    assign bus.cfg_rd_en   = cfg_rd_en_q;
    assign bus.cfg_rd_addr = cfg_rd_addr_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.busy        = (state_q == ST_LOCKED) | cfg_wr_en_q | cfg_rd_en_q | (|rsp_valid_q);
endmodule
